// File: rtl/pkt_builder.sv
// pkt_builder: assembles one packet in the shared packet memory.
//   hdr+0      : {byte_cnt, ecc[3:0]}
//   hdr+1      : {3'b111, ecc_msb, pkt_type}
//   hdr+2..    : N payload bytes copied from addr_in.. (N = byte_cnt+1)
//   hdr+N+2    : CRC-8 (poly 0x07, init 0, MSB-first) over the payload
// Optional feature: define PB_ERR_INJ_EN to add the pb_inj_err input, which
// deliberately corrupts the header ECC or the CRC for receiver testing.
//
// Handshake: pb_start is a request that is taken only on a rising clk edge
// while the block is idle (pb_busy low); requests at any other time are
// dropped, never queued. Completion is a single-cycle pb_irq pulse in DONE.
// Memory reads are synchronous: the byte at mem_addr appears on
// mem_data_o[7:0] in the cycle after the address is driven.
module pkt_builder (
    input  logic        clk,
    input  logic        reset,
    input  logic        pb_start,
    input  logic [13:0] pb_addr_in,
    input  logic [13:0] pb_addr_hdr,
    input  logic [3:0]  pb_byte_cnt,
    input  logic [3:0]  pb_pkt_type,
`ifdef PB_ERR_INJ_EN
    input  logic [1:0]  pb_inj_err,
`endif
    output logic        pb_busy,
    output logic        pb_irq,
    output logic [13:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_data_i,
    input  logic [31:0] mem_data_o,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_WR = 3'd1,
        RD     = 3'd2,
        WR     = 3'd3,
        CRC_WR = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t      state;
    logic [13:0] cfg_src;
    logic [13:0] cfg_hdr;
    logic [3:0]  cfg_cnt;
    logic [3:0]  idx;
    logic [7:0]  crc;
    logic [7:0]  crc_next;
    logic [31:0] data_q;
    logic [15:0] hdr_flip;
    logic [7:0]  crc_flip;
    logic        unused_rd_bits;

    // Header word {byte1, byte0}: Hamming-style ECC over d = {pkt_type, byte_cnt}
    // plus an overall parity bit so double errors can be detected.
    function automatic logic [15:0] hdr_word(input logic [3:0] ptype, input logic [3:0] cnt);
        logic [7:0] d;
        logic [3:0] ecc;
        logic       ecc_msb;
        d       = {ptype, cnt};
        ecc[0]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        ecc[1]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        ecc[2]  = d[1] ^ d[2] ^ d[3] ^ d[7];
        ecc[3]  = d[4] ^ d[5] ^ d[6] ^ d[7];
        ecc_msb = ^d;
        return {3'b111, ecc_msb, ptype, cnt, ecc};
    endfunction

    // One byte of CRC-8, polynomial 0x07, MSB first, no reflection.
    function automatic logic [7:0] crc8_byte(input logic [7:0] cur, input logic [7:0] data);
        logic [7:0] c;
        c = cur ^ data;
        for (int b = 0; b < 8; b++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    assign crc_next = crc8_byte(crc, mem_data_o[7:0]);

    // Upper read lanes are not needed: payload is copied one byte per beat.
    assign unused_rd_bits = ^mem_data_o[31:8];

`ifdef PB_ERR_INJ_EN
    logic [1:0] cfg_inj;

    // Fault masks: header mask uses the live request (header is built on the
    // accept edge), CRC mask uses the value captured with that request.
    always_comb begin
        hdr_flip = 16'h0000;
        crc_flip = 8'h00;
        case (pb_inj_err)
            2'b01:   hdr_flip = 16'h0010;
            2'b10:   hdr_flip = 16'h0030;
            default: hdr_flip = 16'h0000;
        endcase
        if (cfg_inj == 2'b11) begin
            crc_flip = 8'h01;
        end
    end
`else
    assign hdr_flip = 16'h0000;
    assign crc_flip = 8'h00;
`endif

    // Packet sequencer: every memory-side output is registered on entry to
    // the state that owns it, so each state's bus values are stable all cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cfg_src  <= '0;
            cfg_hdr  <= '0;
            cfg_cnt  <= '0;
            idx      <= '0;
            crc      <= '0;
            mem_addr <= '0;
            mem_we   <= '0;
            data_q   <= '0;
`ifdef PB_ERR_INJ_EN
            cfg_inj  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pb_start) begin
                        state    <= HDR_WR;
                        cfg_src  <= pb_addr_in;
                        cfg_hdr  <= pb_addr_hdr;
                        cfg_cnt  <= pb_byte_cnt;
`ifdef PB_ERR_INJ_EN
                        cfg_inj  <= pb_inj_err;
`endif
                        idx      <= 4'h0;
                        crc      <= 8'h00;
                        mem_addr <= pb_addr_hdr;
                        mem_we   <= 4'b0011;
                        data_q   <= {16'h0000, hdr_word(pb_pkt_type, pb_byte_cnt) ^ hdr_flip};
                    end
                end
                HDR_WR: begin
                    state    <= RD;
                    mem_addr <= cfg_src + {10'd0, idx};
                    mem_we   <= 4'b0000;
                    data_q   <= '0;
                end
                RD: begin
                    state    <= WR;
                    mem_addr <= cfg_hdr + 14'd2 + {10'd0, idx};
                    mem_we   <= 4'b0001;
                end
                WR: begin
                    crc <= crc_next;
                    if (idx == cfg_cnt) begin
                        state    <= CRC_WR;
                        mem_addr <= cfg_hdr + {10'd0, cfg_cnt} + 14'd3;
                        mem_we   <= 4'b0001;
                        data_q   <= {24'h000000, crc_next ^ crc_flip};
                    end else begin
                        state    <= RD;
                        idx      <= idx + 4'd1;
                        mem_addr <= cfg_src + {10'd0, idx} + 14'd1;
                        mem_we   <= 4'b0000;
                    end
                end
                CRC_WR: begin
                    state    <= DONE;
                    mem_addr <= '0;
                    mem_we   <= 4'b0000;
                    data_q   <= '0;
                end
                DONE: begin
                    state <= IDLE;
                    idx   <= 4'h0;
                end
                default: begin
                    state  <= IDLE;
                    mem_we <= 4'b0000;
                end
            endcase
        end
    end

    // Payload bytes arrive from memory during WR itself, so they are forwarded
    // straight to the write bus; all other write data comes from data_q.
    assign mem_data_i = (state == WR) ? {24'h000000, mem_data_o[7:0]} : data_q;

    assign pb_busy   = (state != IDLE);
    assign pb_irq    = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_pkt_builder.sv
// tb_pkt_builder: table vectors with hand-derived expected bytes, randomized
// packets scored against a reference model, plus reset/ignored-start sequences.
module tb_pkt_builder;

    logic        clk;
    logic        reset;
    logic        pb_start;
    logic [13:0] pb_addr_in;
    logic [13:0] pb_addr_hdr;
    logic [3:0]  pb_byte_cnt;
    logic [3:0]  pb_pkt_type;
`ifdef PB_ERR_INJ_EN
    logic [1:0]  pb_inj_err;
`endif
    logic        pb_busy;
    logic        pb_irq;
    logic [13:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic [2:0]  dbg_state;

    pkt_builder dut (
        .clk         (clk),
        .reset       (reset),
        .pb_start    (pb_start),
        .pb_addr_in  (pb_addr_in),
        .pb_addr_hdr (pb_addr_hdr),
        .pb_byte_cnt (pb_byte_cnt),
        .pb_pkt_type (pb_pkt_type),
`ifdef PB_ERR_INJ_EN
        .pb_inj_err  (pb_inj_err),
`endif
        .pb_busy     (pb_busy),
        .pb_irq      (pb_irq),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_data_i  (mem_data_i),
        .mem_data_o  (mem_data_o),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    int          irq_cnt  = 0;
    logic [21:0] exp_q[$];          // {addr[13:0], data[7:0]} per expected byte write
    logic [7:0]  mem [0:16383];
    logic [7:0]  pay [0:15];
    logic        host_we;
    logic [13:0] host_addr;
    logic [7:0]  host_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h required=%h", name, act, exp);
        end
    endtask

    // Packet memory: synchronous read, byte-lane writes, plus a bench write port.
    always @(posedge clk) begin
        mem_data_o <= {mem[mem_addr + 14'd3], mem[mem_addr + 14'd2],
                       mem[mem_addr + 14'd1], mem[mem_addr]};
        for (int k = 0; k < 4; k++) begin
            if (mem_we[k]) mem[mem_addr + 14'(k)] = mem_data_i[8*k +: 8];
        end
        if (host_we) mem[host_addr] = host_data;
    end

    // Write monitor: every byte written must be the next expected one.
    always @(negedge clk) begin
        logic [21:0] got;
        logic [21:0] e;
        if (reset === 1'b1 && mem_we !== 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_we[k]) begin
                    got = {mem_addr + 14'(k), mem_data_i[8*k +: 8]};
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL spurious_write got=%h required=none", got);
                    end else begin
                        e = exp_q.pop_front();
                        check("mem_write", 32'(got), 32'(e));
                    end
                end
            end
        end
        if (pb_irq === 1'b1) irq_cnt++;
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] hdr_ref(input logic [3:0] t, input logic [3:0] c);
        logic [7:0] d;
        logic [3:0] ecc;
        d      = {t, c};
        ecc[0] = ^(d & 8'h5B);
        ecc[1] = ^(d & 8'h6D);
        ecc[2] = ^(d & 8'h8E);
        ecc[3] = ^(d & 8'hF0);
        return {3'b111, ^d, t, c, ecc};
    endfunction

    // CRC as the remainder of (payload bit string * x^8) mod x^8+x^2+x+1.
    function automatic logic [7:0] crc_ref(input int n);
        logic [8:0] rem;
        rem = 9'h000;
        for (int i = 0; i < n + 1; i++) begin
            for (int b = 7; b >= 0; b--) begin
                rem = {rem[7:0], (i < n) ? pay[i][b] : 1'b0};
                if (rem[8]) rem = rem ^ 9'h107;
                if (i == n && b == 0) break;
            end
        end
        return rem[7:0];
    endfunction

    task automatic model_pkt(input logic [3:0] t, input logic [3:0] c,
                             input logic [13:0] h, input logic [1:0] inj);
        logic [15:0] hw;
        logic [7:0]  cr;
        hw = hdr_ref(t, c);
        cr = crc_ref(int'(c) + 1);
        if (inj == 2'b01) hw = hw ^ 16'h0010;
        if (inj == 2'b10) hw = hw ^ 16'h0030;
        if (inj == 2'b11) cr = cr ^ 8'h01;
        exp_q.push_back({h, hw[7:0]});
        exp_q.push_back({h + 14'd1, hw[15:8]});
        for (int i = 0; i <= int'(c); i++) exp_q.push_back({h + 14'd2 + 14'(i), pay[i]});
        exp_q.push_back({h + 14'd3 + {10'd0, c}, cr});
    endtask

    // ---------------- drivers ----------------
    task automatic host_write(input logic [13:0] a, input logic [7:0] d);
        @(negedge clk);
        host_addr = a;
        host_data = d;
        host_we   = 1'b1;
        @(negedge clk);
        host_we   = 1'b0;
    endtask

    task automatic scramble_cfg();
        pb_addr_in  = 14'($urandom);
        pb_addr_hdr = 14'($urandom);
        pb_byte_cnt = 4'($urandom);
        pb_pkt_type = 4'($urandom);
`ifdef PB_ERR_INJ_EN
        pb_inj_err  = 2'($urandom);
`endif
    endtask

    // Load payload, run one packet, check latency/busy/irq; poke=1 keeps
    // hammering pb_start while busy and through DONE.
    task automatic run_pkt(input logic [3:0] t, input logic [3:0] c,
                           input logic [13:0] s, input logic [13:0] h,
                           input logic [1:0] inj, input bit poke);
        int lat;
        int irq_before;
        for (int i = 0; i <= int'(c); i++) host_write(s + 14'(i), pay[i]);
        model_pkt(t, c, h, inj);
        irq_before = irq_cnt;
        @(negedge clk);
        pb_start    = 1'b1;
        pb_pkt_type = t;
        pb_byte_cnt = c;
        pb_addr_in  = s;
        pb_addr_hdr = h;
`ifdef PB_ERR_INJ_EN
        pb_inj_err  = inj;
`endif
        @(posedge clk);
        #1;
        pb_start = 1'b0;
        scramble_cfg();
        lat = 0;
        for (int j = 1; j <= 100 && lat == 0; j++) begin
            @(negedge clk);
            if (pb_irq === 1'b1) begin
                lat = j;
            end else begin
                check("busy_during_pkt", 32'(pb_busy), 32'd1);
                if (poke) begin
                    pb_start = 1'b1;
                    scramble_cfg();
                end
            end
        end
        check("irq_latency", lat, 2 * (int'(c) + 1) + 3);
        @(negedge clk);
        pb_start = 1'b0;
        check("idle_after_done", 32'({pb_busy, pb_irq}), 32'd0);
        @(negedge clk);
        check("idle_stays", 32'(pb_busy), 32'd0);
        check("writes_pending", exp_q.size(), 0);
        check("irq_count", irq_cnt - irq_before, 1);
    endtask

    // ---------------- test table ----------------
    typedef struct packed {
        logic [3:0]  t;
        logic [3:0]  c;
        logic [13:0] h;
        logic [13:0] s;
        logic [7:0]  fill;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  crc;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [3:0]  t;
        logic [3:0]  c;
        logic [13:0] s;
        logic [13:0] h;
        logic [1:0]  inj;
        int          irq_before;
        bit          found;

        vecs[0] = '{4'h0, 4'h3, 14'h0010, 14'h0100, 8'h00, 8'h36, 8'hE0, 8'h00};
        vecs[1] = '{4'h0, 4'h0, 14'h0020, 14'h0110, 8'h01, 8'h00, 8'hE0, 8'h07};
        vecs[2] = '{4'h0, 4'h1, 14'h0030, 14'h0120, 8'h00, 8'h13, 8'hF0, 8'h00};
        vecs[3] = '{4'h0, 4'h0, 14'h3FFE, 14'h0130, 8'h01, 8'h00, 8'hE0, 8'h07};
        vecs[4] = '{4'hF, 4'hF, 14'h0040, 14'h0140, 8'h00, 8'hF3, 8'hEF, 8'h00};
        vecs[5] = '{4'h5, 4'h1, 14'h0060, 14'h0160, 8'h01, 8'h11, 8'hF5, 8'h12};

        // reset block
        reset     = 1'b0;
        pb_start  = 1'b0;
        host_we   = 1'b0;
        host_addr = '0;
        host_data = '0;
        scramble_cfg();
`ifdef PB_ERR_INJ_EN
        pb_inj_err = 2'b00;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(pb_busy), 32'd0);
        check("rst_irq", 32'(pb_irq), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_data_i, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // table vectors
        foreach (vecs[v]) begin
            for (int i = 0; i <= int'(vecs[v].c); i++) pay[i] = vecs[v].fill;
            run_pkt(vecs[v].t, vecs[v].c, vecs[v].s, vecs[v].h, 2'b00, 1'b0);
            check("hdr_byte0", 32'(mem[vecs[v].h]), 32'(vecs[v].b0));
            check("hdr_byte1", 32'(mem[vecs[v].h + 14'd1]), 32'(vecs[v].b1));
            for (int i = 0; i <= int'(vecs[v].c); i++)
                check("payload_byte", 32'(mem[vecs[v].h + 14'd2 + 14'(i)]), 32'(vecs[v].fill));
            check("crc_byte", 32'(mem[vecs[v].h + 14'd3 + {10'd0, vecs[v].c}]), 32'(vecs[v].crc));
        end

        // pb_start held during RD..DONE must be ignored
        for (int i = 0; i < 3; i++) pay[i] = 8'($urandom);
        run_pkt(4'h9, 4'h2, 14'h0200, 14'h2000, 2'b00, 1'b1);

        // randomized packets against the model
        for (int n = 0; n < 20; n++) begin
            t = 4'($urandom);
            c = 4'($urandom);
            s = 14'($urandom_range(32'h0100, 32'h0EFF));
            h = 14'($urandom_range(32'h1000, 32'h3FFF));
            inj = 2'b00;
`ifdef PB_ERR_INJ_EN
            inj = 2'($urandom_range(0, 3));
`endif
            for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
            run_pkt(t, c, s, h, inj, 1'($urandom_range(0, 1)));
        end

`ifdef PB_ERR_INJ_EN
        // single-bit header corruption
        for (int i = 0; i < 4; i++) pay[i] = 8'h00;
        run_pkt(4'h0, 4'h3, 14'h0300, 14'h0500, 2'b01, 1'b0);
        check("inj_hdr_byte0", 32'(mem[14'h0500]), 32'h26);
`endif

        // reset while writing payload: no further writes, no restart
        for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) host_write(14'h0600 + 14'(i), pay[i]);
        model_pkt(4'h3, 4'h3, 14'h3000, 2'b00);
        irq_before = irq_cnt;
        @(negedge clk);
        pb_start    = 1'b1;
        pb_pkt_type = 4'h3;
        pb_byte_cnt = 4'h3;
        pb_addr_in  = 14'h0600;
        pb_addr_hdr = 14'h3000;
`ifdef PB_ERR_INJ_EN
        pb_inj_err  = 2'b00;
`endif
        @(posedge clk);
        #1;
        pb_start = 1'b0;
        found = 1'b0;
        for (int j = 0; j < 20 && !found; j++) begin
            @(negedge clk);
            if (mem_we === 4'b0001) found = 1'b1;
        end
        check("reached_wr", 32'(found), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_we", 32'(mem_we), 32'd0);
        check("async_rst_busy", 32'(pb_busy), 32'd0);
        check("async_rst_state", 32'(dbg_state), 32'd0);
        check("async_rst_addr", 32'(mem_addr), 32'd0);
        check("async_rst_wdata", mem_data_i, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check("no_restart", 32'(pb_busy), 32'd0);
        end
        check("irq_after_reset", irq_cnt - irq_before, 0);

        // fresh packet after reset runs normally
        for (int i = 0; i < 2; i++) pay[i] = 8'($urandom);
        run_pkt(4'hA, 4'h1, 14'h0700, 14'h3100, 2'b00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
